// File: rtl/icache_refill.sv
// Memory-side responder for I-cache misses: captures a miss, waits a fixed latency,
// then returns the 128-bit line and tag with a one-cycle fill strobe.
module icache_refill #(
  parameter int TAG_W     = 9,
  parameter int MEM_IDX_W = 5,
  parameter int LATENCY   = 5
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   ICacheMiss,
  input  logic [TAG_W-1:0]       ICacheMiss_tag,
  output logic                   WiCache,
  output logic [127:0]           WiCacheline,
  output logic [TAG_W-1:0]       WiCachetag,
  output logic                   busy,
  input  logic                   ld_we,
  input  logic [MEM_IDX_W+1:0]   ld_addr,
  input  logic [31:0]            ld_data
);

  localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  typedef enum logic [1:0] {IDLE, WAIT, RESP, HOLD} state_t;

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   cnt;
  logic [TAG_W-1:0]   tag_q;
  logic [127:0]       mem [2**MEM_IDX_W];
  logic               fire;

  assign fire = (state == WAIT) && (cnt == '0);
  assign busy = (state != IDLE);

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (ICacheMiss) state_nxt = WAIT;
      WAIT:    if (cnt == '0)  state_nxt = RESP;
      RESP:    state_nxt = HOLD;
      HOLD:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers see pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt         <= '0;
      tag_q       <= '0;
      WiCache     <= 1'b0;
      WiCacheline <= '0;
      WiCachetag  <= '0;
    end else begin
      WiCache <= fire;
      if (state == IDLE && ICacheMiss) begin
        tag_q <= ICacheMiss_tag;
        cnt   <= CNT_W'(LATENCY - 1);
      end else if (state == WAIT) begin
        if (cnt != '0) begin
          cnt <= cnt - 1'b1;
        end else begin
          // Tags beyond the store size alias onto the low index bits.
          WiCacheline <= mem[tag_q[MEM_IDX_W-1:0]];
          WiCachetag  <= tag_q;
        end
      end
    end
  end

  // NOTE: the backing store is deliberately not reset; it keeps loaded programs across resets.
  always_ff @(posedge clk) begin
    if (ld_we)
      mem[ld_addr[MEM_IDX_W+1:2]][{ld_addr[1:0], 5'b0} +: 32] <= ld_data;
  end

endmodule

// File: tb/tb_icache_refill.sv
// Directed bench for icache_refill: fill latency, aliasing, back-to-back misses,
// tag changes during WAIT, load-port collision and reset during WAIT.
module tb_icache_refill;

  localparam int TAG_W = 9;
  localparam int MIW   = 5;
  localparam int LAT   = 5;

  localparam logic [127:0] LINE3  = 128'h44444444_33333333_22222222_11111111;
  localparam logic [127:0] LINE3B = 128'h44444444_33333333_22222222_DEADBEEF;
  localparam logic [127:0] LINE4  = 128'hAAAA0003_AAAA0002_AAAA0001_AAAA0000;
  localparam logic [127:0] LINE7  = 128'h77770003_77770002_77770001_77770000;

  logic             clk = 1'b0;
  logic             reset;
  logic             ICacheMiss;
  logic [TAG_W-1:0] ICacheMiss_tag;
  logic             WiCache;
  logic [127:0]     WiCacheline;
  logic [TAG_W-1:0] WiCachetag;
  logic             busy;
  logic             ld_we;
  logic [MIW+1:0]   ld_addr;
  logic [31:0]      ld_data;

  int n_checks = 0;
  int n_fail   = 0;

  icache_refill #(.TAG_W(TAG_W), .MEM_IDX_W(MIW), .LATENCY(LAT)) dut (
    .clk            (clk),
    .reset          (reset),
    .ICacheMiss     (ICacheMiss),
    .ICacheMiss_tag (ICacheMiss_tag),
    .WiCache        (WiCache),
    .WiCacheline    (WiCacheline),
    .WiCachetag     (WiCachetag),
    .busy           (busy),
    .ld_we          (ld_we),
    .ld_addr        (ld_addr),
    .ld_data        (ld_data)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance one rising edge and settle; outputs are sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ld_line(input logic [MIW-1:0] idx, input logic [127:0] line);
    for (int w = 0; w < 4; w++) begin
      ld_we   = 1'b1;
      ld_addr = {idx, 2'(w)};
      ld_data = line[w*32 +: 32];
      tick();
    end
    ld_we = 1'b0;
  endtask

  // Present a miss in IDLE and walk it through capture, WAIT, RESP, HOLD back to IDLE.
  task automatic do_fill(input string name, input logic [TAG_W-1:0] t,
                         input logic [127:0] exp_line, input logic [TAG_W-1:0] exp_tag);
    ICacheMiss     = 1'b1;
    ICacheMiss_tag = t;
    tick();
    check({name, " busy after capture"}, 128'(busy), 128'(1'b1));
    for (int i = 1; i < LAT; i++) begin
      tick();
      check({name, " no early strobe"}, 128'(WiCache), 128'(1'b0));
    end
    tick();
    check({name, " strobe"}, 128'(WiCache), 128'(1'b1));
    check({name, " line"}, WiCacheline, exp_line);
    check({name, " tag"}, 128'(WiCachetag), 128'(exp_tag));
    ICacheMiss = 1'b0;
    tick();
    check({name, " strobe single cycle"}, 128'(WiCache), 128'(1'b0));
    check({name, " busy in HOLD"}, 128'(busy), 128'(1'b1));
    tick();
    check({name, " idle after HOLD"}, 128'(busy), 128'(1'b0));
  endtask

  initial begin
    reset = 1'b1; ICacheMiss = 1'b0; ICacheMiss_tag = '0;
    ld_we = 1'b0; ld_addr = '0; ld_data = '0;
    repeat (3) tick();
    check("reset WiCache", 128'(WiCache), 128'(1'b0));
    check("reset line", WiCacheline, 128'h0);
    check("reset tag", 128'(WiCachetag), 128'h0);
    check("reset busy", 128'(busy), 128'(1'b0));

    // Load port works regardless of FSM state; install the test lines.
    reset = 1'b0;
    ld_line(5'd3, LINE3);
    ld_line(5'd4, LINE4);
    ld_line(5'd7, LINE7);

    // Single fill of line 3 followed by a miss re-raised during HOLD.
    ICacheMiss = 1'b1; ICacheMiss_tag = 9'd3;
    tick();
    check("fill3 busy after capture", 128'(busy), 128'(1'b1));
    for (int i = 1; i < LAT; i++) begin
      tick();
      check("fill3 no early strobe", 128'(WiCache), 128'(1'b0));
    end
    tick();
    check("fill3 strobe", 128'(WiCache), 128'(1'b1));
    check("fill3 line", WiCacheline, LINE3);
    check("fill3 tag", 128'(WiCachetag), 128'd3);
    ICacheMiss = 1'b0;
    tick();
    check("fill3 strobe single cycle", 128'(WiCache), 128'(1'b0));
    check("fill3 busy in HOLD", 128'(busy), 128'(1'b1));
    ICacheMiss = 1'b1; ICacheMiss_tag = 9'd4;
    tick();
    check("b2b no capture in HOLD", 128'(busy), 128'(1'b0));
    check("b2b no duplicate strobe", 128'(WiCache), 128'(1'b0));
    check("b2b line held", WiCacheline, LINE3);
    tick();
    check("b2b capture in IDLE", 128'(busy), 128'(1'b1));
    for (int i = 1; i < LAT; i++) begin
      tick();
      check("b2b no early strobe", 128'(WiCache), 128'(1'b0));
    end
    tick();
    check("b2b strobe", 128'(WiCache), 128'(1'b1));
    check("b2b line", WiCacheline, LINE4);
    check("b2b tag", 128'(WiCachetag), 128'd4);
    ICacheMiss = 1'b0;
    tick();
    tick();
    check("b2b idle", 128'(busy), 128'(1'b0));

    do_fill("alias35", 9'd35, LINE3, 9'd35);

    // Tag change and request drop two cycles after capture must not disturb the fill.
    ICacheMiss = 1'b1; ICacheMiss_tag = 9'd3;
    tick();
    tick();
    tick();
    ICacheMiss_tag = 9'd7; ICacheMiss = 1'b0;
    for (int i = 3; i < LAT; i++) begin
      tick();
      check("tagchg no early strobe", 128'(WiCache), 128'(1'b0));
    end
    tick();
    check("tagchg strobe", 128'(WiCache), 128'(1'b1));
    check("tagchg line", WiCacheline, LINE3);
    check("tagchg tag", 128'(WiCachetag), 128'd3);
    tick();
    tick();
    tick();
    check("tagchg no new capture", 128'(busy), 128'(1'b0));

    // Write to line 3 word 0 on the WAIT->RESP edge: read returns old data.
    ICacheMiss = 1'b1; ICacheMiss_tag = 9'd3;
    tick();
    for (int i = 1; i < LAT; i++) tick();
    ld_we = 1'b1; ld_addr = {5'd3, 2'd0}; ld_data = 32'hDEADBEEF;
    tick();
    ld_we = 1'b0; ICacheMiss = 1'b0;
    check("collide strobe", 128'(WiCache), 128'(1'b1));
    check("collide old data", WiCacheline, LINE3);
    tick();
    tick();
    do_fill("after collide", 9'd3, LINE3B, 9'd3);

    // Reset with cnt==2 in WAIT discards the miss; release with miss still high re-captures.
    ICacheMiss = 1'b1; ICacheMiss_tag = 9'd4;
    tick();
    tick();
    tick();
    reset = 1'b1;
    for (int i = 0; i < LAT + 2; i++) begin
      tick();
      check("rst WiCache", 128'(WiCache), 128'(1'b0));
    end
    check("rst line", WiCacheline, 128'h0);
    check("rst tag", 128'(WiCachetag), 128'h0);
    check("rst busy", 128'(busy), 128'(1'b0));
    reset = 1'b0;
    tick();
    check("post-rst capture", 128'(busy), 128'(1'b1));
    for (int i = 1; i < LAT; i++) begin
      tick();
      check("post-rst no early strobe", 128'(WiCache), 128'(1'b0));
    end
    tick();
    check("post-rst strobe", 128'(WiCache), 128'(1'b1));
    check("post-rst line", WiCacheline, LINE4);
    check("post-rst tag", 128'(WiCachetag), 128'd4);
    ICacheMiss = 1'b0;
    tick();
    tick();
    check("post-rst idle", 128'(busy), 128'(1'b0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
